// File: rtl/voice_allocator_if.sv
// Key-switch and voice-output bundle of voice_allocator.
// The master drives the switches; the slave (the allocator) drives everything else.
interface voice_allocator_if #(
    parameter int NKEYS   = 36,
    parameter int NVOICES = 4
);
    logic [NKEYS-1:0]     switches;
    logic [NVOICES-1:0]   voice_wave;
    logic [NVOICES-1:0]   voice_active;
    logic [6*NVOICES-1:0] voice_key;
    logic                 speaker;
    logic                 full;
    logic                 drop;

    modport master (
        output switches,
        input  voice_wave, voice_active, voice_key, speaker, full, drop
    );

    modport slave (
        input  switches,
        output voice_wave, voice_active, voice_key, speaker, full, drop
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: a scan FSM shares NVOICES square-wave voices among NKEYS keys.
// Build macro VOICE_STEAL_EN: when all voices are busy a new key steals one round-robin.
module voice_allocator #(
    parameter int NKEYS   = 36,
    parameter int NVOICES = 4,
    parameter int CLK_MHZ = 1,
    parameter int CW      = 21
) (
    input  logic             clk,
    input  logic             rst,
    voice_allocator_if.slave bus
);

    localparam int KW = 6;
    localparam int VW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

    // Half-period counts at 1 MHz, C3 upward in semitones.
    localparam int unsigned TABLE [36] = '{
        3822, 3608, 3405, 3214, 3034, 2864, 2703, 2551, 2408, 2273, 2145, 2025,
        1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012,
         956,  902,  851,  804,  758,  716,  676,  638,  602,  568,  536,  506
    };

    typedef enum logic [1:0] {SCAN, ALLOC, FREE} state_t;

    state_t                         state_q, state_d;
    logic [NKEYS-1:0]               sync1_q, sync2_q;
    logic [KW-1:0]                  idx_q, idx_d, next_idx;
    logic [NKEYS-1:0]               assigned_q, assigned_d;
    logic [VW-1:0]                  sel_q, sel_d;
    logic [NVOICES-1:0]             voice_active_q, voice_active_d;
    logic [NVOICES-1:0]             wave_q, wave_d;
    logic [NVOICES-1:0][KW-1:0]     voice_key_q, voice_key_d;
    logic [NVOICES-1:0][CW-1:0]     counter_q, counter_d;
    logic [NVOICES-1:0][CW-1:0]     limit_q, limit_d;
    logic                           full_q, full_d;
    logic                           drop;
`ifdef VOICE_STEAL_EN
    logic [NKEYS-1:0]               lockout_q, lockout_d;
    logic [VW-1:0]                  steal_ptr_q, steal_ptr_d;
    logic                           steal_q, steal_d;
`endif

    logic          pressed, key_asg, key_lck, key_new;
    logic [VW-1:0] free_idx, hold_idx;

    assign pressed = sync2_q[idx_q];
    assign key_asg = assigned_q[idx_q];
`ifdef VOICE_STEAL_EN
    assign key_lck = lockout_q[idx_q];
`else
    assign key_lck = 1'b0;
`endif
    assign key_new  = pressed && !key_asg && !key_lck;
    assign next_idx = (idx_q == KW'(NKEYS - 1)) ? '0 : idx_q + 1'b1;

    // Lowest free voice, and the voice currently holding the scanned key.
    always_comb begin
        free_idx = '0;
        hold_idx = '0;
        for (int v = NVOICES - 1; v >= 0; v--) begin
            if (!voice_active_q[v]) free_idx = VW'(v);
            if (voice_active_q[v] && voice_key_q[v] == idx_q) hold_idx = VW'(v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= SCAN;
        else     state_q <= state_d;
    end

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        state_d = SCAN;
        sel_d   = sel_q;
`ifdef VOICE_STEAL_EN
        steal_d = steal_q;
`endif
        case (state_q)
            SCAN: begin
                if (key_new && !full_q) begin
                    state_d = ALLOC;
                    sel_d   = free_idx;
`ifdef VOICE_STEAL_EN
                    steal_d = 1'b0;
                end else if (key_new) begin
                    state_d = ALLOC;
                    sel_d   = steal_ptr_q;
                    steal_d = 1'b1;
`endif
                end else if (!pressed && key_asg) begin
                    state_d = FREE;
                    sel_d   = hold_idx;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        idx_d          = idx_q;
        assigned_d     = assigned_q;
        voice_active_d = voice_active_q;
        voice_key_d    = voice_key_q;
        counter_d      = counter_q;
        limit_d        = limit_q;
        wave_d         = wave_q;
        drop           = 1'b0;
`ifdef VOICE_STEAL_EN
        lockout_d      = lockout_q;
        steal_ptr_d    = steal_ptr_q;
`endif
        for (int v = 0; v < NVOICES; v++) begin
            if (!voice_active_q[v]) begin
                counter_d[v] = '0;
                wave_d[v]    = 1'b0;
            end else if (counter_q[v] == limit_q[v]) begin
                counter_d[v] = '0;
                wave_d[v]    = ~wave_q[v];
            end else begin
                counter_d[v] = counter_q[v] + 1'b1;
            end
        end

        case (state_q)
            SCAN: begin
`ifdef VOICE_STEAL_EN
                if (!pressed && key_lck) lockout_d[idx_q] = 1'b0;
`else
                drop = key_new && full_q;
`endif
                if (state_d == SCAN) idx_d = next_idx;
            end
            ALLOC: begin
`ifdef VOICE_STEAL_EN
                // The victim key stays silent until it is released.
                if (steal_q) begin
                    assigned_d[voice_key_q[sel_q]] = 1'b0;
                    lockout_d[voice_key_q[sel_q]]  = 1'b1;
                    steal_ptr_d = (steal_ptr_q == VW'(NVOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
                end
`endif
                voice_active_d[sel_q] = 1'b1;
                voice_key_d[sel_q]    = idx_q;
                assigned_d[idx_q]     = 1'b1;
                limit_d[sel_q]        = CW'(CLK_MHZ * TABLE[idx_q]);
                counter_d[sel_q]      = '0;
                wave_d[sel_q]         = 1'b0;
                idx_d                 = next_idx;
            end
            FREE: begin
                voice_active_d[sel_q] = 1'b0;
                counter_d[sel_q]      = '0;
                wave_d[sel_q]         = 1'b0;
                assigned_d[idx_q]     = 1'b0;
                idx_d                 = next_idx;
            end
            default: ;
        endcase

        full_d = &voice_active_d;
    end

    // NOTE: every flop including the per-key and per-voice arrays is reset, so a reset mid-action leaves no stale voice.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            idx_q          <= '0;
            assigned_q     <= '0;
            sel_q          <= '0;
            voice_active_q <= '0;
            wave_q         <= '0;
            voice_key_q    <= '0;
            counter_q      <= '0;
            limit_q        <= '0;
            full_q         <= 1'b0;
`ifdef VOICE_STEAL_EN
            lockout_q      <= '0;
            steal_ptr_q    <= '0;
            steal_q        <= 1'b0;
`endif
        end else begin
            sync1_q        <= bus.switches;
            sync2_q        <= sync1_q;
            idx_q          <= idx_d;
            assigned_q     <= assigned_d;
            sel_q          <= sel_d;
            voice_active_q <= voice_active_d;
            wave_q         <= wave_d;
            voice_key_q    <= voice_key_d;
            counter_q      <= counter_d;
            limit_q        <= limit_d;
            full_q         <= full_d;
`ifdef VOICE_STEAL_EN
            lockout_q      <= lockout_d;
            steal_ptr_q    <= steal_ptr_d;
            steal_q        <= steal_d;
`endif
        end
    end

    assign bus.voice_wave   = wave_q;
    assign bus.voice_active = voice_active_q;
    assign bus.voice_key    = voice_key_q;
    assign bus.speaker      = |(wave_q & voice_active_q);
    assign bus.full         = full_q;
    assign bus.drop         = drop;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler for the piano keyboard. It shares NVOICES tone-generator voices among NKEYS key switches, so the design no longer needs one divider and one speaker pin per note. A scan FSM walks the keys, allocates free voices to newly pressed keys, releases voices when keys go up, and drives one square wave per voice plus a mixed speaker line. It sits between the key switch inputs and the speaker pins.

Parameters:
NKEYS, 36, number of key inputs; index 0 = C3 … 35 = B5, chromatic.
NVOICES, 4, number of shared tone voices (1..8).
CLK_MHZ, 1, clock in MHz; each half-period limit is CLK_MHZ*TABLE[k].
CW, 21, voice counter width in bits.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
switches  in  NKEYS  raw key levels, 1 = pressed
voice_wave  out  NVOICES  square wave per voice
voice_active  out  NVOICES  voice currently assigned
voice_key  out  6*NVOICES  key index held by each voice; field v = bits [6v+5:6v]
speaker  out  1  OR of (voice_wave & voice_active)
full  out  1  all voices active
drop  out  1  one-cycle pulse when a pressed key finds no voice

Behaviour:
- Reset (rst=1 at posedge clk):
  - all outputs 0; synchronizer, assigned[], lockout[] and voice counters all 0.
  - scan index = 0; state = SCAN.
- switches pass through a 2-flop synchronizer, adding 2 cycles of latency. The FSM uses only synchronized values.
- TABLE[0..35] (half-period counts at 1 MHz):
  - 3822 3608 3405 3214 3034 2864 2703 2551 2408 2273 2145 2025
  - 1911 1804 1703 1607 1517 1432 1351 1276 1204 1136 1073 1012
  - 956 902 851 804 758 716 676 638 602 568 536 506
- FSM states SCAN, ALLOC, FREE. Key k = current scan index; a key is evaluated only in SCAN.
  - SCAN, pressed & !assigned[k] & !lockout[k] & free voice exists -> ALLOC. A free voice exists when some voice_active bit is 0; pick the lowest such index.
  - SCAN, !pressed & assigned[k] -> FREE.
  - SCAN, !pressed & lockout[k] -> clear lockout[k], advance, stay in SCAN.
  - SCAN, pressed & !assigned & !lockout & full -> drop=1 for this cycle, advance, stay in SCAN (steal behaviour: see Optional Feature).
  - SCAN, any other case -> advance, stay in SCAN.
  - ALLOC (1 cycle), for the chosen voice v:
    - voice_active[v]=1; voice_key[v]=k; assigned[k]=1.
    - limit[v]=CLK_MHZ*TABLE[k]; counter[v]=0; voice_wave[v]=0.
    - advance; -> SCAN.
  - FREE (1 cycle):
    - the voice holding k gets voice_active=0, voice_wave=0, counter held at 0.
    - assigned[k]=0; advance; -> SCAN.
- Advance: index wraps NKEYS-1 -> 0. A full sweep with no actions takes NKEYS cycles; each action adds 1 cycle.
- Voice engine, per active voice, every cycle:
  - if counter==limit: counter<=0 and wave toggles; else counter+1.
  - Wave period = 2*(limit+1) cycles.
  - A voice allocated in the same cycle restarts from 0 and does not toggle in that cycle.
- full = &voice_active; it is registered and updates in the cycle after ALLOC/FREE.
- A key change between scans is seen only at that key's next evaluation. Release-then-press within one sweep is invisible.
- Without steal, a pressed key that got drop retries on every sweep and is allocated as soon as a voice frees.
- rst mid-ALLOC or mid-FREE wins: everything returns to reset values.

Optional Feature:
VOICE_STEAL_EN
- Defined: in SCAN, when a key is pressed & !assigned & !lockout & full:
  - FSM -> ALLOC on voice steal_ptr instead of pulsing drop.
  - The previous key of that voice gets assigned=0, lockout=1; it stays silent until released.
  - steal_ptr increments mod NVOICES after each steal and resets to 0.
  - drop never asserts.
- Undefined: drop and retry as above. No steal_ptr; lockout is never set.

Test Plan:
- Reset, then press key 9 (A3) only -> within 2+36+1 cycles voice 0 is active with key 9; wave period is 4548 cycles; speaker follows voice_wave[0].
- Press keys 0,12,24,35 together -> voices 0..3 hold keys 0,12,24,35 in scan order; full=1 the cycle after the 4th ALLOC.
- With all 4 voices held, press key 5 (macro off) -> drop pulses once per sweep (every 36 cycles); after key 12 is released, key 5 takes voice 1 on the next sweep with limit 2864.
- Same stimulus with VOICE_STEAL_EN -> key 5 steals voice 0 and drop stays 0. Key 0 is locked out; releasing and re-pressing key 0 steals voice 1.
- Release key 24 -> voice 2 has voice_active=0 and wave=0 one cycle after its FREE; full drops to 0.
- Assert rst for 1 cycle during an ALLOC -> all outputs 0 next cycle; the scan restarts at key 0 and held keys are re-allocated from voice 0.
